// File: rtl/mem_bridge_pkg.sv
// Shared types, widths and line lane helpers for the word-to-line memory bridge.
// A line holds four 16-bit words; word i sits in bits [16i+15:16i].
package mem_bridge_pkg;

  localparam int LINE_W = 64;
  localparam int WORD_W = 16;
  localparam int TAG_W  = 13;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    WR_WAIT,
    RESP
  } state_t;

  function automatic logic [WORD_W-1:0] lane_get(input logic [LINE_W-1:0] line,
                                                 input logic [1:0]        idx);
    lane_get = line[int'(idx)*WORD_W +: WORD_W];
  endfunction

  function automatic logic [LINE_W-1:0] lane_put(input logic [LINE_W-1:0] line,
                                                 input logic [1:0]        idx,
                                                 input logic [WORD_W-1:0] word);
    lane_put = line;
    lane_put[int'(idx)*WORD_W +: WORD_W] = word;
  endfunction

endpackage

// File: rtl/mem_word_bridge_if.sv
// Core word port and memory line port of the bridge. The slave modport is the
// bridge's view; the master modport is the core/memory environment around it.
interface mem_word_bridge_if;
  import mem_bridge_pkg::*;

  logic              cpuReq;
  logic              cpuWr;
  logic [15:0]       cpuAddr;
  logic [WORD_W-1:0] cpuData;
  logic              cpuReady;
  logic              cpuDone;
  logic [WORD_W-1:0] cpuOut;

  logic              memStart;
  logic              memIsRd;
  logic [15:0]       memAddr;
  logic [LINE_W-1:0] memData;
  logic [LINE_W-1:0] memOut;
  logic              memFinish;

  modport slave (
    input  cpuReq, cpuWr, cpuAddr, cpuData, memOut, memFinish,
    output cpuReady, cpuDone, cpuOut, memStart, memIsRd, memAddr, memData
  );

  modport master (
    output cpuReq, cpuWr, cpuAddr, cpuData, memOut, memFinish,
    input  cpuReady, cpuDone, cpuOut, memStart, memIsRd, memAddr, memData
  );

endinterface

// File: rtl/line_buf.sv
// Single-entry line buffer: tag, valid and one 64-bit line with a hit compare.
// With ENABLE=0 the entry never becomes valid, so every lookup misses.
module line_buf
  import mem_bridge_pkg::*;
#(
  parameter bit ENABLE = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              load,
  input  logic [TAG_W-1:0]  loadTag,
  input  logic [LINE_W-1:0] loadLine,
  input  logic [TAG_W-1:0]  lookupTag,
  output logic              hit,
  output logic [LINE_W-1:0] line
);

  logic             valid;
  logic [TAG_W-1:0] tag;

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= ENABLE;
    end
  end

  // NOTE: tag and data are qualified by valid, so they carry no reset and stay plain storage.
  always_ff @(posedge clk) begin
    if (load) begin
      tag  <= loadTag;
      line <= loadLine;
    end
  end

  assign hit = valid && (tag == lookupTag);

endmodule

// File: rtl/mem_word_bridge.sv
// Turns 16-bit core reads/writes into 64-bit line transactions; writes are
// read-modify-write, and a write-through line buffer short-circuits same-line hits.
module mem_word_bridge
  import mem_bridge_pkg::*;
#(
  parameter bit LINE_BUF = 1'b1
) (
  input logic               clk,
  input logic               rstn,
  mem_word_bridge_if.slave  bus
);

  state_t            state, nextState;
  logic              reqWr;
  logic [15:1]       reqAddr;
  logic [WORD_W-1:0] reqData;

  logic              curWr;
  logic [TAG_W-1:0]  curTag;
  logic [1:0]        curIdx;
  logic [WORD_W-1:0] curData;

  logic              bufHit;
  logic [LINE_W-1:0] bufLine;
  logic              bufLoad;
  logic [LINE_W-1:0] loadLine;
  logic [WORD_W-1:0] respWord;
  logic              unusedAddrBit;

  assign unusedAddrBit = bus.cpuAddr[0];

  // In IDLE the request is still on the bus; afterwards it lives in the latches.
  always_comb begin
    if (state == IDLE) begin
      curWr   = bus.cpuWr;
      curTag  = bus.cpuAddr[15:3];
      curIdx  = bus.cpuAddr[2:1];
      curData = bus.cpuData;
    end else begin
      curWr   = reqWr;
      curTag  = reqAddr[15:3];
      curIdx  = reqAddr[2:1];
      curData = reqData;
    end
  end

  line_buf #(.ENABLE(LINE_BUF)) u_line_buf (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (state == INIT),
    .load      (bufLoad),
    .loadTag   (curTag),
    .loadLine  (loadLine),
    .lookupTag (curTag),
    .hit       (bufHit),
    .line      (bufLine)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    nextState = state;
    bufLoad   = 1'b0;
    loadLine  = bus.memOut;
    respWord  = '0;
    unique case (state)
      INIT:     if (bus.memFinish) nextState = IDLE;
      IDLE: begin
        if (bus.cpuReq) begin
          if (bufHit && !curWr) begin
            respWord  = lane_get(bufLine, curIdx);
            nextState = RESP;
          end else if (bufHit) begin
            bufLoad   = 1'b1;
            loadLine  = lane_put(bufLine, curIdx, curData);
            nextState = WR_ISSUE;
          end else begin
            nextState = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: nextState = RD_WAIT;
      RD_WAIT: begin
        if (bus.memFinish) begin
          bufLoad = 1'b1;
          if (curWr) begin
            loadLine  = lane_put(bus.memOut, curIdx, curData);
            nextState = WR_ISSUE;
          end else begin
            respWord  = lane_get(bus.memOut, curIdx);
            nextState = RESP;
          end
        end
      end
      WR_ISSUE: nextState = WR_WAIT;
      WR_WAIT:  if (bus.memFinish) nextState = RESP;
      RESP:     nextState = IDLE;
      default:  nextState = INIT;
    endcase
  end

  // Outputs are registered from nextState so they line up with the state they describe.
  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= INIT;
      reqWr        <= 1'b0;
      reqAddr      <= '0;
      reqData      <= '0;
      bus.cpuReady <= 1'b0;
      bus.cpuDone  <= 1'b0;
      bus.cpuOut   <= '0;
      bus.memStart <= 1'b0;
      bus.memIsRd  <= 1'b0;
      bus.memAddr  <= '0;
      bus.memData  <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && bus.cpuReq) begin
        reqWr   <= bus.cpuWr;
        reqAddr <= bus.cpuAddr[15:1];
        reqData <= bus.cpuData;
      end
      bus.cpuReady <= (nextState == IDLE);
      bus.cpuDone  <= (nextState == RESP);
      bus.cpuOut   <= respWord;
      bus.memStart <= (nextState == RD_ISSUE) || (nextState == WR_ISSUE);
      if (nextState == RD_ISSUE) begin
        bus.memIsRd <= 1'b1;
        bus.memAddr <= {curTag, 3'b000};
        bus.memData <= '0;
      end else if (nextState == WR_ISSUE) begin
        bus.memIsRd <= 1'b0;
        bus.memAddr <= {curTag, 3'b000};
        bus.memData <= loadLine;
      end
    end
  end

endmodule
